// File: rtl/fifo_word_unpacker.sv
// Pops words from a registered-read FIFO and serialises each into four bytes on a valid/ready stream.
// First byte two cycles after the pop strobe; 4 bytes per 5 cycles with byte_ready held high.
module fifo_word_unpacker #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       out_q, out_d;
  logic             last_q, last_d;
  logic             pop_ok;
  logic             accept;

  function automatic logic [7:0] pick(input logic [WIDTH-1:0] w, input logic [1:0] i);
    if (LSB_FIRST) return w[8*int'(i) +: 8];
    else           return w[8*(3-int'(i)) +: 8];
  endfunction

  assign byte_valid = (state_q == SEND);
  assign accept     = byte_valid && byte_ready;
  assign pop_ok     = enable && !fifo_empty;
  assign byte_out   = out_q;
  assign byte_last  = last_q;
  assign busy       = (state_q != IDLE);
  assign word_count = count_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    count_d    = count_q;
    out_d      = out_q;
    last_d     = last_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop_ok) begin
          fifo_rd_en = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // Registered FIFO read: the popped word is only visible now.
        word_d  = fifo_data;
        idx_d   = 2'd0;
        out_d   = pick(fifo_data, 2'd0);
        last_d  = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            count_d = count_q + CNT_W'(1);
            last_d  = 1'b0;
            if (pop_ok) begin
              fifo_rd_en = 1'b1;
              state_d    = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d  = idx_q + 2'd1;
            out_d  = pick(word_q, idx_q + 2'd1);
            last_d = (idx_q == 2'd2);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= 2'd0;
      count_q <= '0;
      out_q   <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: two instances (LSB-first/16-bit count, MSB-first/2-bit count) fed by FIFO models.
module tb_fifo_word_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, byte_ready;
  logic        empty0, empty1, rd0, rd1;
  logic [31:0] data0, data1;
  logic [7:0]  bo0, bo1;
  logic        bv0, bv1, bl0, bl1, busy0, busy1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  fifo_word_unpacker #(.WIDTH(32), .LSB_FIRST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(empty0), .fifo_rd_en(rd0),
    .fifo_data(data0), .byte_out(bo0), .byte_valid(bv0), .byte_ready(byte_ready),
    .byte_last(bl0), .busy(busy0), .word_count(cnt0));

  fifo_word_unpacker #(.WIDTH(32), .LSB_FIRST(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(empty1), .fifo_rd_en(rd1),
    .fifo_data(data1), .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready),
    .byte_last(bl1), .busy(busy1), .word_count(cnt1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_cnt0 = 0;
  logic [31:0] word_b;

  // FIFO models: registered read, data appears the cycle after the strobe.
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  int push0_n = 0, pop0_n = 0, under0 = 0;
  int push1_n = 0, pop1_n = 0, under1 = 0;
  assign empty0 = (push0_n == pop0_n);
  assign empty1 = (push1_n == pop1_n);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) begin
      if (empty0) under0 <= under0 + 1;
      else begin data0 <= mem0[pop0_n % 64]; pop0_n <= pop0_n + 1; end
    end
    if (rd1) begin
      if (empty1) under1 <= under1 + 1;
      else begin data1 <= mem1[pop1_n % 64]; pop1_n <= pop1_n + 1; end
    end
  end

  typedef struct { logic [7:0] b; logic last; int cyc; } acc_t;
  acc_t acc0[$];
  acc_t acc1[$];
  int   rd0_cyc[$];
  logic [1:0] cnt1_seen[$];
  logic [1:0] cnt1_prev = 2'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd0) rd0_cyc.push_back(cyc);
      if (bv0 && byte_ready) acc0.push_back('{bo0, bl0, cyc});
      if (bv1 && byte_ready) acc1.push_back('{bo1, bl1, cyc});
      if (cnt1 != cnt1_prev) begin cnt1_seen.push_back(cnt1); cnt1_prev = cnt1; end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i, input bit lsb);
    logic [31:0] t;
    t = lsb ? (w >> (8*i)) : (w >> (8*(3-i)));
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push0(input logic [31:0] w);
    mem0[push0_n % 64] = w;
    push0_n = push0_n + 1;
  endtask

  task automatic push1(input logic [31:0] w);
    mem1[push1_n % 64] = w;
    push1_n = push1_n + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; byte_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (bv0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bv0); end
    checks++; if (bo0 !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", bo0); end
    checks++; if (bl0 !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bl0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    checks++; if (bv1 !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b want 0", bv1); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    acc0.delete(); rd0_cyc.delete();
    enable = 1'b1; byte_ready = 1'b1;
    push0(w);
    repeat (10) tick();
    checks++; if (rd0_cyc.size() !== 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd0_cyc.size()); end
    checks++; if (acc0.size() !== 4) begin errors++; $display("FAIL single_byte_count: got %0d want 4", acc0.size()); end
    for (int i = 0; i < acc0.size() && i < 4 && rd0_cyc.size() > 0; i++) begin
      checks++; if (acc0[i].b !== exp_byte(w, i, 1'b1)) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, acc0[i].b, exp_byte(w, i, 1'b1)); end
      checks++; if (acc0[i].last !== (i == 3)) begin errors++; $display("FAIL single_last%0d: got %b want %b", i, acc0[i].last, (i == 3)); end
      checks++; if (acc0[i].cyc !== rd0_cyc[0] + 2 + i) begin errors++; $display("FAIL single_timing%0d: got cycle %0d want %0d", i, acc0[i].cyc, rd0_cyc[0] + 2 + i); end
    end
    exp_cnt0 = exp_cnt0 + 1;
    checks++; if (cnt0 !== 16'(exp_cnt0)) begin errors++; $display("FAIL single_count: got %0d want %0d", cnt0, exp_cnt0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b want 0", busy0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [2];
    w[0] = 32'h03020100; w[1] = 32'h07060504;
    acc0.delete(); rd0_cyc.delete();
    push0(w[0]); push0(w[1]);
    repeat (16) tick();
    checks++; if (rd0_cyc.size() !== 2) begin errors++; $display("FAIL b2b_rd_count: got %0d want 2", rd0_cyc.size()); end
    checks++; if (acc0.size() !== 8) begin errors++; $display("FAIL b2b_byte_count: got %0d want 8", acc0.size()); end
    for (int i = 0; i < acc0.size() && i < 8; i++) begin
      checks++; if (acc0[i].b !== exp_byte(w[i/4], i%4, 1'b1)) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, acc0[i].b, exp_byte(w[i/4], i%4, 1'b1)); end
    end
    if (acc0.size() == 8 && rd0_cyc.size() == 2) begin
      checks++; if (rd0_cyc[1] !== acc0[3].cyc) begin errors++; $display("FAIL b2b_rd_with_last: got cycle %0d want %0d", rd0_cyc[1], acc0[3].cyc); end
      checks++; if (acc0[4].cyc - acc0[3].cyc !== 2) begin errors++; $display("FAIL b2b_gap: got %0d want 2", acc0[4].cyc - acc0[3].cyc); end
    end
    exp_cnt0 = exp_cnt0 + 2;
    checks++; if (cnt0 !== 16'(exp_cnt0)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    int n;
    w = 32'h11223344;
    acc0.delete();
    push0(w);
    n = 0;
    while (acc0.size() < 1 && n < 20) begin tick(); n++; end
    checks++; if (acc0.size() < 1) begin errors++; $display("FAIL bp_wait: got %0d bytes want 1 within 20 cycles", acc0.size()); end
    byte_ready = 1'b0;
    rd0_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bv0 !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", k, bv0); end
      checks++; if (bo0 !== exp_byte(w, 1, 1'b1)) begin errors++; $display("FAIL bp_hold%0d: got %h want %h", k, bo0, exp_byte(w, 1, 1'b1)); end
      checks++; if (bl0 !== 1'b0) begin errors++; $display("FAIL bp_last%0d: got %b want 0", k, bl0); end
      checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL bp_rd%0d: got %b want 0", k, rd0); end
    end
    tick();
    byte_ready = 1'b1;
    repeat (8) tick();
    checks++; if (acc0.size() !== 4) begin errors++; $display("FAIL bp_byte_count: got %0d want 4", acc0.size()); end
    for (int i = 0; i < acc0.size() && i < 4; i++) begin
      checks++; if (acc0[i].b !== exp_byte(w, i, 1'b1)) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, acc0[i].b, exp_byte(w, i, 1'b1)); end
    end
    checks++; if (rd0_cyc.size() !== 0) begin errors++; $display("FAIL bp_no_rd: got %0d strobes want 0", rd0_cyc.size()); end
    exp_cnt0 = exp_cnt0 + 1;
    checks++; if (cnt0 !== 16'(exp_cnt0)) begin errors++; $display("FAIL bp_count: got %0d want %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_gating();
    logic [31:0] wa;
    logic busy_seen;
    int n;
    acc0.delete(); rd0_cyc.delete();
    busy_seen = 1'b0;
    repeat (6) begin @(negedge clk); if (busy0) busy_seen = 1'b1; end
    checks++; if (rd0_cyc.size() !== 0) begin errors++; $display("FAIL gate_empty_rd: got %0d strobes want 0", rd0_cyc.size()); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL gate_empty_busy: got %b want 0", busy_seen); end
    tick();
    enable = 1'b0;
    wa = $urandom; word_b = $urandom;
    push0(wa); push0(word_b);
    busy_seen = 1'b0;
    repeat (6) begin @(negedge clk); if (busy0) busy_seen = 1'b1; end
    checks++; if (rd0_cyc.size() !== 0) begin errors++; $display("FAIL gate_disabled_rd: got %0d strobes want 0", rd0_cyc.size()); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL gate_disabled_busy: got %b want 0", busy_seen); end
    tick();
    enable = 1'b1;
    n = 0;
    while (acc0.size() < 1 && n < 20) begin tick(); n++; end
    enable = 1'b0;
    repeat (10) tick();
    checks++; if (acc0.size() !== 4) begin errors++; $display("FAIL gate_drop_bytes: got %0d want 4", acc0.size()); end
    for (int i = 0; i < acc0.size() && i < 4; i++) begin
      checks++; if (acc0[i].b !== exp_byte(wa, i, 1'b1)) begin errors++; $display("FAIL gate_drop_byte%0d: got %h want %h", i, acc0[i].b, exp_byte(wa, i, 1'b1)); end
    end
    checks++; if (rd0_cyc.size() !== 1) begin errors++; $display("FAIL gate_drop_rd: got %0d strobes want 1", rd0_cyc.size()); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL gate_drop_idle: got busy %b want 0", busy0); end
    checks++; if (push0_n - pop0_n !== 1) begin errors++; $display("FAIL gate_drop_left: got %0d words left want 1", push0_n - pop0_n); end
    exp_cnt0 = exp_cnt0 + 1;
    checks++; if (cnt0 !== 16'(exp_cnt0)) begin errors++; $display("FAIL gate_count: got %0d want %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_reset_mid_word();
    logic busy_seen;
    int n;
    acc0.delete();
    enable = 1'b1; byte_ready = 1'b1;
    n = 0;
    while (acc0.size() < 2 && n < 20) begin tick(); n++; end
    checks++; if (bv0 !== 1'b1 || bo0 !== exp_byte(word_b, 2, 1'b1)) begin errors++; $display("FAIL rst_pre: got valid %b byte %h want 1 %h", bv0, bo0, exp_byte(word_b, 2, 1'b1)); end
    rst_n = 1'b0;
    #1;
    checks++; if (bv0 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bv0); end
    checks++; if (bo0 !== 8'h00) begin errors++; $display("FAIL rst_mid_byte: got %h want 00", bo0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", cnt0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy0); end
    exp_cnt0 = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    rd0_cyc.delete();
    busy_seen = 1'b0;
    repeat (6) begin @(negedge clk); if (busy0) busy_seen = 1'b1; end
    checks++; if (rd0_cyc.size() !== 0) begin errors++; $display("FAIL rst_after_rd: got %0d strobes want 0", rd0_cyc.size()); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL rst_after_busy: got %b want 0", busy_seen); end
    checks++; if (acc0.size() !== 2) begin errors++; $display("FAIL rst_after_bytes: got %0d want 2", acc0.size()); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] w [6];
    logic [7:0] prev_b;
    logic prev_l, held;
    int n, stall_err;
    acc0.delete();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin w[i] = $urandom; push0(w[i]); end
    n = 0; held = 1'b0; stall_err = 0; prev_b = 8'h00; prev_l = 1'b0;
    while (acc0.size() < 24 && n < 400) begin
      tick();
      byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (held && (bv0 !== 1'b1 || bo0 !== prev_b || bl0 !== prev_l)) stall_err++;
      held = bv0 && !byte_ready;
      prev_b = bo0; prev_l = bl0;
      n++;
    end
    tick();
    byte_ready = 1'b1;
    tick();
    checks++; if (acc0.size() !== 24) begin errors++; $display("FAIL rand_byte_count: got %0d want 24", acc0.size()); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL rand_stall_stable: got %0d violations want 0", stall_err); end
    for (int i = 0; i < acc0.size() && i < 24; i++) begin
      checks++; if (acc0[i].b !== exp_byte(w[i/4], i%4, 1'b1) || acc0[i].last !== (i%4 == 3)) begin
        errors++; $display("FAIL rand_byte%0d: got %h/%b want %h/%b", i, acc0[i].b, acc0[i].last, exp_byte(w[i/4], i%4, 1'b1), (i%4 == 3));
      end
    end
    exp_cnt0 = exp_cnt0 + 6;
    checks++; if (cnt0 !== 16'(exp_cnt0)) begin errors++; $display("FAIL rand_count: got %0d want %0d", cnt0, exp_cnt0); end
    checks++; if (under0 !== 0) begin errors++; $display("FAIL rand_underflow: got %0d strobes on empty want 0", under0); end
  endtask

  task automatic test_msb_wrap();
    logic [31:0] w [5];
    int n;
    acc1.delete(); cnt1_seen.delete();
    enable = 1'b1;
    w[0] = 32'hA1B2C3D4;
    for (int i = 1; i < 5; i++) w[i] = $urandom;
    for (int i = 0; i < 5; i++) push1(w[i]);
    n = 0;
    while (acc1.size() < 20 && n < 400) begin
      tick();
      byte_ready = 1'($urandom_range(0, 1));
      n++;
    end
    tick();
    byte_ready = 1'b1;
    repeat (2) tick();
    checks++; if (acc1.size() !== 20) begin errors++; $display("FAIL msb_byte_count: got %0d want 20", acc1.size()); end
    for (int i = 0; i < acc1.size() && i < 20; i++) begin
      checks++; if (acc1[i].b !== exp_byte(w[i/4], i%4, 1'b0) || acc1[i].last !== (i%4 == 3)) begin
        errors++; $display("FAIL msb_byte%0d: got %h/%b want %h/%b", i, acc1[i].b, acc1[i].last, exp_byte(w[i/4], i%4, 1'b0), (i%4 == 3));
      end
    end
    checks++; if (cnt1_seen.size() !== 5) begin errors++; $display("FAIL wrap_len: got %0d count changes want 5", cnt1_seen.size()); end
    for (int k = 0; k < cnt1_seen.size() && k < 5; k++) begin
      checks++; if (cnt1_seen[k] !== 2'((k + 1) % 4)) begin errors++; $display("FAIL wrap_count%0d: got %0d want %0d", k, cnt1_seen[k], (k + 1) % 4); end
    end
    checks++; if (under1 !== 0) begin errors++; $display("FAIL msb_underflow: got %0d strobes on empty want 0", under1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gating();
    test_reset_mid_word();
    test_random();
    test_msb_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
